// File: rtl/sccb_config_sequencer_if.sv
// Handshake bundle between the config sequencer and the SCCB master.
interface sccb_config_sequencer_if;
  logic       sccb_start;
  logic       sccb_rw;
  logic [7:0] sccb_reg;
  logic [7:0] sccb_wdata;
  logic [7:0] sccb_rdata;
  logic       sccb_nack;
  logic       sccb_ready;

  modport master (output sccb_start, sccb_rw, sccb_reg, sccb_wdata,
                  input  sccb_rdata, sccb_nack, sccb_ready);
  modport slave  (input  sccb_start, sccb_rw, sccb_reg, sccb_wdata,
                  output sccb_rdata, sccb_nack, sccb_ready);
endinterface

// File: rtl/sccb_config_sequencer.sv
// Table-driven SCCB configuration engine: walks a registered ROM of WRITE /
// WRITE_VERIFY / DELAY / END entries, retrying failed entries and flagging errors.
module sccb_config_sequencer #(
  parameter int CLK_FREQ      = 25000000,
  parameter int ROM_AW        = 8,
  parameter int DELAY_UNIT_US = 1000,
  parameter int MAX_RETRY     = 3
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  output logic [ROM_AW-1:0]          rom_addr,
  input  logic [17:0]                rom_data,
  sccb_config_sequencer_if.master    sccb,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [ROM_AW-1:0]          err_addr
);
  localparam int CYC_PER_UNIT = CLK_FREQ / 1000000 * DELAY_UNIT_US;
  localparam int DW = 8 + $clog2(CYC_PER_UNIT + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam logic [DW-1:0]     CYC_W = DW'(CYC_PER_UNIT);
  localparam logic [ROM_AW-1:0] LAST  = '1;
  localparam logic [1:0] OP_WR = 2'd0, OP_WV = 2'd1, OP_DLY = 2'd2;

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, DELAY, NEXT, DONE, FAIL
  } state_t;

  state_t        state, state_nx;
  logic [DW-1:0] dly_cnt;
  logic [RW-1:0] retry_cnt;
  logic          verify, seen_low;
  logic          complete, bad, start_ok, can_retry, to_done, to_fail;

  assign start_ok  = start && (state == IDLE || state == DONE || state == FAIL);
  // A transaction is finished only once ready has dropped and come back.
  assign complete  = sccb.sccb_ready && seen_low;
  assign can_retry = retry_cnt < RW'(MAX_RETRY);
  assign to_done   = (state_nx == DONE) && (state != DONE);
  assign to_fail   = (state_nx == FAIL) && (state != FAIL);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx        = state;
    sccb.sccb_start = 1'b0;
    bad             = 1'b0;
    case (state)
      IDLE, DONE, FAIL: if (start) state_nx = FETCH;
      FETCH:  state_nx = DECODE;
      DECODE: case (rom_data[17:16])
        OP_WR, OP_WV: state_nx = WR_REQ;
        OP_DLY:       state_nx = (rom_data[7:0] == 8'd0) ? NEXT : DELAY;
        default:      state_nx = DONE;
      endcase
      WR_REQ: if (sccb.sccb_ready) begin
        sccb.sccb_start = 1'b1;
        state_nx        = WR_WAIT;
      end
      WR_WAIT: if (complete) begin
        if (sccb.sccb_nack) bad = 1'b1;
        else                state_nx = verify ? RD_REQ : NEXT;
      end
      RD_REQ: if (sccb.sccb_ready) begin
        sccb.sccb_start = 1'b1;
        state_nx        = RD_WAIT;
      end
      RD_WAIT: if (complete) begin
        if (sccb.sccb_nack || sccb.sccb_rdata != sccb.sccb_wdata) bad = 1'b1;
        else                                                     state_nx = NEXT;
      end
      DELAY:   if (dly_cnt == DW'(1)) state_nx = NEXT;
      NEXT:    state_nx = (rom_addr == LAST) ? DONE : FETCH;
      default: state_nx = IDLE;
    endcase
    if (bad) state_nx = can_retry ? WR_REQ : FAIL;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rom_addr        <= '0;
      sccb.sccb_rw    <= 1'b0;
      sccb.sccb_reg   <= '0;
      sccb.sccb_wdata <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b0;
      err_addr        <= '0;
      dly_cnt         <= '0;
      retry_cnt       <= '0;
      verify          <= 1'b0;
      seen_low        <= 1'b0;
    end else begin
      if (sccb.sccb_start)      seen_low <= 1'b0;
      else if (!sccb.sccb_ready) seen_low <= 1'b1;

      if (start_ok) begin
        rom_addr  <= '0;
        busy      <= 1'b1;
        done      <= 1'b0;
        error     <= 1'b0;
        retry_cnt <= '0;
      end

      case (state)
        DECODE: begin
          sccb.sccb_reg   <= rom_data[15:8];
          sccb.sccb_wdata <= rom_data[7:0];
          verify          <= (rom_data[17:16] == OP_WV);
          dly_cnt         <= DW'(rom_data[7:0]) * CYC_W;
        end
        DELAY: dly_cnt <= dly_cnt - 1'b1;
        NEXT: begin
          retry_cnt <= '0;
          if (rom_addr != LAST) rom_addr <= rom_addr + 1'b1;
        end
        default: ;
      endcase

      // Every attempt, first or retried, starts with the write half.
      if (state_nx == RD_REQ)      sccb.sccb_rw <= 1'b1;
      else if (state_nx == WR_REQ) sccb.sccb_rw <= 1'b0;

      if (bad && can_retry) retry_cnt <= retry_cnt + 1'b1;

      if (to_fail) begin
        error    <= 1'b1;
        err_addr <= rom_addr;
        busy     <= 1'b0;
      end
      if (to_done) begin
        done <= 1'b1;
        busy <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sccb_config_sequencer.sv
// Randomized bench: SCCB slave with scripted faults, checked against a table-walk reference model.
module tb_sccb_config_sequencer;
  localparam int AW = 3, DEPTH = 8, CYC = 10, MAXR = 3, LIM = 5000;
  localparam logic [17:0] END_E = {2'd3, 16'h0};

  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic [AW-1:0] rom_addr, err_addr;
  logic [17:0] rom_data;
  logic busy, done, error;
  logic [17:0] rom [DEPTH];

  sccb_config_sequencer_if sif ();

  sccb_config_sequencer #(.CLK_FREQ(1000000), .ROM_AW(AW), .DELAY_UNIT_US(10), .MAX_RETRY(MAXR)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .sccb(sif), .busy(busy), .done(done), .error(error), .err_addr(err_addr));

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // SCCB slave: fault code per transaction (0 ok, 1 nack, 2 corrupt read data)
  logic [1:0] fault [256];
  logic [7:0] regf [256];
  logic       cap_rw [64];
  logic [7:0] cap_reg [64], cap_dat [64];
  int fidx = 0, ncap = 0, lat = 0, proto_err = 0, lat_max = 2;
  logic cur_rw;
  logic [7:0] cur_reg, cur_wd;
  logic [1:0] cur_f;

  always @(posedge clk) begin
    if (!reset_n) begin
      sif.sccb_ready <= 1'b1;
      sif.sccb_nack  <= 1'b0;
      sif.sccb_rdata <= 8'h00;
      lat            <= 0;
    end else begin
      if (start && !busy) begin
        fidx <= 0;
        ncap <= 0;
      end
      if (sif.sccb_start) begin
        if (!sif.sccb_ready) proto_err <= proto_err + 1;
        cur_rw  <= sif.sccb_rw;
        cur_reg <= sif.sccb_reg;
        cur_wd  <= sif.sccb_wdata;
        cur_f   <= fault[fidx];
        fidx    <= fidx + 1;
        if (ncap < 64) begin
          cap_rw[ncap]  <= sif.sccb_rw;
          cap_reg[ncap] <= sif.sccb_reg;
          cap_dat[ncap] <= sif.sccb_wdata;
          ncap          <= ncap + 1;
        end
        sif.sccb_ready <= 1'b0;
        lat            <= $urandom_range(1, lat_max);
      end else if (!sif.sccb_ready) begin
        if (lat > 1) lat <= lat - 1;
        else begin
          sif.sccb_ready <= 1'b1;
          if (sif.sccb_rw !== cur_rw || sif.sccb_reg !== cur_reg || sif.sccb_wdata !== cur_wd)
            proto_err <= proto_err + 1;
          sif.sccb_nack <= (cur_f == 2'd1);
          if (cur_rw) sif.sccb_rdata <= (cur_f == 2'd2) ? (regf[cur_reg] ^ 8'h10) : regf[cur_reg];
          else if (cur_f != 2'd1) regf[cur_reg] <= cur_wd;
        end
      end
    end
  end

  // Reference model: walk the table entry by entry, consuming one fault code per transaction.
  logic [16:0] exp_tr [$];
  logic exp_done, exp_err, has_sccb;
  int exp_eaddr, exp_lat;

  task automatic model();
    int t = 0;
    logic ok;
    logic [1:0] op;
    logic [7:0] r, v;
    exp_tr.delete();
    exp_done = 0; exp_err = 0; exp_eaddr = 0; exp_lat = 0; has_sccb = 0;
    for (int a = 0; a < DEPTH; a++) begin
      op = rom[a][17:16]; r = rom[a][15:8]; v = rom[a][7:0];
      if (op == 2'd3) begin exp_done = 1; exp_lat += 2; return; end
      exp_lat += 3;
      if (op == 2'd2) begin exp_lat += int'(v) * CYC; continue; end
      has_sccb = 1;
      ok = 0;
      for (int k = 0; k <= MAXR && !ok; k++) begin
        exp_tr.push_back({1'b0, r, v});
        t++;
        if (fault[t-1] == 2'd1) continue;
        if (op == 2'd0) ok = 1;
        else begin
          exp_tr.push_back({1'b1, r, v});
          t++;
          ok = (fault[t-1] == 2'd0);
        end
      end
      if (!ok) begin exp_err = 1; exp_eaddr = a; return; end
    end
    exp_done = 1;
  endtask

  task automatic set_faults(input int mode);
    for (int i = 0; i < 256; i++)
      case (mode)
        0: fault[i] = 2'd0;
        1: fault[i] = 2'd1;
        2: fault[i] = 2'd2;
        default: fault[i] = ($urandom_range(0, 6) == 0) ? 2'($urandom_range(1, 2)) : 2'd0;
      endcase
  endtask

  task automatic run(input string tag, input int poke);
    int cyc = 0;
    model();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (!(done || error) && cyc < LIM) begin
      @(negedge clk);
      cyc++;
      start = (cyc == poke);
    end
    start = 1'b0;
    chk({tag, ".timeout"}, cyc >= LIM, 0);
    chk({tag, ".done"}, done, exp_done);
    chk({tag, ".error"}, error, exp_err);
    chk({tag, ".busy"}, busy, 0);
    if (exp_err) chk({tag, ".err_addr"}, err_addr, exp_eaddr);
    if (!has_sccb) chk({tag, ".lat"}, cyc, exp_lat);
    chk({tag, ".ntr"}, ncap, exp_tr.size());
    for (int i = 0; i < exp_tr.size() && i < ncap; i++)
      chk($sformatf("%s.tr%0d", tag, i), {cap_rw[i], cap_reg[i], cap_dat[i]}, exp_tr[i]);
    chk({tag, ".proto"}, proto_err, 0);
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, ".rom_addr"}, rom_addr, 0);
    chk({tag, ".sccb_start"}, sif.sccb_start, 0);
    chk({tag, ".sccb_rw"}, sif.sccb_rw, 0);
    chk({tag, ".sccb_reg"}, sif.sccb_reg, 0);
    chk({tag, ".sccb_wdata"}, sif.sccb_wdata, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".error"}, error, 0);
    chk({tag, ".err_addr"}, err_addr, 0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) rom[i] = END_E;
    for (int i = 0; i < 256; i++) regf[i] = 8'h00;
    set_faults(0);
    repeat (3) @(negedge clk);
    rst_chk("reset");
    reset_n = 1'b1;
    @(negedge clk);

    rom[0] = {2'd0, 8'h12, 8'h80};
    run("write1", -1);
    chk("write1.n", ncap, 1);

    rom[0] = {2'd2, 8'h00, 8'd3};
    run("delay3", -1);
    chk("delay3.cyc", exp_lat, 35);
    rom[0] = {2'd2, 8'h00, 8'd0};
    run("delay0", -1);

    rom[0] = {2'd1, 8'h40, 8'hD0};
    fault[1] = 2'd2; fault[3] = 2'd2; fault[5] = 2'd2;
    run("verify_retry", -1);
    chk("verify_retry.n", ncap, 8);

    for (int i = 0; i < 5; i++) rom[i] = {2'd2, 8'h00, 8'd0};
    rom[5] = {2'd1, 8'h40, 8'hD0};
    set_faults(2);
    run("verify_fail", -1);
    chk("verify_fail.addr", err_addr, 5);
    set_faults(1);
    run("nack_fail", -1);
    chk("nack_fail.n", ncap, 4);

    for (int i = 0; i < DEPTH; i++) rom[i] = END_E;
    set_faults(0);
    rom[0] = {2'd0, 8'h3A, 8'h04}; rom[1] = {2'd1, 8'h12, 8'h14}; rom[2] = {2'd2, 8'h00, 8'd2};
    run("mid_start", 10);

    rom[0] = {2'd0, 8'h11, 8'h22}; rom[1] = {2'd2, 8'h00, 8'd200}; rom[2] = END_E;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (60) @(negedge clk);
    chk("rst_mid.busy", busy, 1);
    reset_n = 1'b0;
    @(negedge clk);
    rst_chk("rst_mid");
    reset_n = 1'b1;
    rom[0] = {2'd0, 8'h6B, 8'h4A}; rom[1] = END_E;
    run("after_rst", -1);

    for (int i = 0; i < DEPTH; i++) rom[i] = {2'd0, 8'(i + 8'h20), 8'($urandom)};
    run("exhaust", -1);
    chk("exhaust.rom_addr", rom_addr, DEPTH - 1);

    for (int it = 0; it < 25; it++) begin
      int w;
      lat_max = $urandom_range(1, 4);
      for (int i = 0; i < DEPTH; i++) begin
        w = $urandom_range(0, 9);
        if (w < 4)      rom[i] = {2'd0, 8'($urandom), 8'($urandom)};
        else if (w < 7) rom[i] = {2'd1, 8'($urandom), 8'($urandom)};
        else if (w < 9) rom[i] = {2'd2, 8'($urandom), 8'($urandom_range(0, 3))};
        else            rom[i] = END_E;
      end
      set_faults(3);
      run($sformatf("rand%0d", it), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
